// File: rtl/cam_pixel_capture.sv
// Camera DVP capture: packs bus words into pixels, tracks x/y and frame count,
// flags malformed lines and drops frames on request.
module cam_pixel_capture #(
   parameter int unsigned BUS_W         = 8,
   parameter int unsigned BYTES_PER_PIX = 2,
   parameter int unsigned H_ACTIVE      = 640,
   parameter int unsigned X_W           = 12,
   parameter int unsigned Y_W           = 11,
   parameter bit          VS_POL        = 1'b1,
   localparam int unsigned PIX_W        = BUS_W * BYTES_PER_PIX
) (
   input  logic             i_pclk,
   input  logic             i_rst_n,
   input  logic [BUS_W-1:0] i_data,
   input  logic             i_href,
   input  logic             i_vsync,
   input  logic [3:0]       i_skip,
   output logic [PIX_W-1:0] o_pixel,
   output logic             o_valid,
   output logic [X_W-1:0]   o_x,
   output logic [Y_W-1:0]   o_y,
   output logic             o_sof,
   output logic             o_eol,
   output logic             o_eof,
   output logic             o_line_err,
   output logic [15:0]      o_frame_cnt
);

   localparam int unsigned IDX_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;

   typedef enum logic [1:0] {StWaitVs, StInVs, StActive, StSkip} state_e;

   state_e             r_state;
   state_e             w_state_next;
   logic               r_href_d;
   logic [IDX_W-1:0]   r_idx;
   logic [X_W-1:0]     r_x;
   logic               r_x_ovf;
   logic [Y_W-1:0]     r_y;
   logic [3:0]         r_skip_cnt;
   logic [PIX_W-1:0]   r_acc;
   logic [PIX_W-1:0]   w_acc_next;
   logic [PIX_W-1:0]   r_pixel;
   logic               r_valid;
   logic [X_W-1:0]     r_ox;
   logic [Y_W-1:0]     r_oy;
   logic               r_sof;
   logic               r_eol;
   logic               r_eof;
   logic               r_err;
   logic [15:0]        r_frame_cnt;

   logic w_vs;
   logic w_href_fall;
   logic w_word;
   logic w_last;
   logic w_eol;
   logic w_eof;
   logic w_enter_active;

   assign w_vs           = (i_vsync == VS_POL);
   assign w_href_fall    = r_href_d & ~i_href;
   // VSYNC wins over any line activity in the same cycle
   assign w_word         = (r_state == StActive) && !w_vs && i_href;
   assign w_last         = (32'(r_idx) == BYTES_PER_PIX - 1);
   assign w_eol          = (r_state == StActive) && !w_vs && w_href_fall;
   assign w_eof          = (r_state == StActive) && w_vs;
   assign w_enter_active = (r_state == StInVs) && (w_state_next == StActive);

   always_ff @(posedge i_pclk) begin
      if (!i_rst_n) begin
         r_state <= StWaitVs;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StWaitVs: if (w_vs) w_state_next = StInVs;
         StInVs:   if (!w_vs) w_state_next = (r_skip_cnt == 4'd0) ? StActive : StSkip;
         StActive: if (w_vs) w_state_next = StInVs;
         StSkip:   if (w_vs) w_state_next = StInVs;
         default:  w_state_next = StWaitVs;
      endcase
   end

   // First word of a pixel lands in the most significant slot
   always_comb begin
      w_acc_next = r_acc;
      for (int unsigned k = 0; k < BYTES_PER_PIX; k++) begin
         if (32'(r_idx) == BYTES_PER_PIX - 1 - k) begin
            w_acc_next[k*BUS_W +: BUS_W] = i_data;
         end
      end
   end

   always_ff @(posedge i_pclk) begin
      if (!i_rst_n) begin
         r_href_d    <= 1'b0;
         r_idx       <= '0;
         r_x         <= '0;
         r_x_ovf     <= 1'b0;
         r_y         <= '0;
         r_skip_cnt  <= 4'd0;
         r_acc       <= '0;
         r_pixel     <= '0;
         r_valid     <= 1'b0;
         r_ox        <= '0;
         r_oy        <= '0;
         r_sof       <= 1'b0;
         r_eol       <= 1'b0;
         r_eof       <= 1'b0;
         r_err       <= 1'b0;
         r_frame_cnt <= 16'd0;
      end else begin
         r_href_d <= i_href;
         r_valid  <= 1'b0;
         r_sof    <= 1'b0;
         r_eol    <= 1'b0;
         r_eof    <= 1'b0;
         r_err    <= 1'b0;

         if (w_enter_active) begin
            r_idx   <= '0;
            r_x     <= '0;
            r_x_ovf <= 1'b0;
            r_y     <= '0;
         end

         if (w_eof) begin
            r_eof       <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_skip_cnt  <= i_skip;
         end

         if ((r_state == StSkip) && w_vs) begin
            r_skip_cnt <= r_skip_cnt - 4'd1;
         end

         if (w_word) begin
            r_acc <= w_acc_next;
            if (w_last) begin
               r_idx   <= '0;
               r_pixel <= w_acc_next;
               r_valid <= 1'b1;
               r_ox    <= r_x;
               r_oy    <= r_y;
               r_sof   <= (r_x == '0) && (r_y == '0);
               // Sticky overflow keeps over-long lines failing the length check
               if (r_x == '1) begin
                  r_x_ovf <= 1'b1;
               end else begin
                  r_x <= r_x + 1'b1;
               end
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end

         if (w_eol) begin
            r_eol   <= 1'b1;
            r_err   <= (r_idx != '0) || r_x_ovf || (32'(r_x) != H_ACTIVE);
            r_idx   <= '0;
            r_x     <= '0;
            r_x_ovf <= 1'b0;
            if (((r_x != '0) || r_x_ovf) && (r_y != '1)) begin
               r_y <= r_y + 1'b1;
            end
         end
      end
   end

   assign o_pixel     = r_pixel;
   assign o_valid     = r_valid;
   assign o_x         = r_ox;
   assign o_y         = r_oy;
   assign o_sof       = r_sof;
   assign o_eol       = r_eol;
   assign o_eof       = r_eof;
   assign o_line_err  = r_err;
   assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Bench for cam_pixel_capture: frame/line-level scoreboard for a 2-word-pixel instance plus
// directed literal checks on a 3-word-pixel instance.
module tb_cam_pixel_capture;

   localparam int BPP  = 2;
   localparam int HACT = 4;
   localparam bit VSP  = 1'b1;
   localparam int MWait = 0;
   localparam int MCap  = 1;
   localparam int MSkip = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        i_rst_n;
   logic [7:0]  i_data;
   logic        i_href;
   logic        i_vsync;
   logic [3:0]  i_skip;
   logic [15:0] o_pixel;
   logic        o_valid;
   logic [11:0] o_x;
   logic [10:0] o_y;
   logic        o_sof;
   logic        o_eol;
   logic        o_eof;
   logic        o_line_err;
   logic [15:0] o_frame_cnt;

   logic        b3_rst_n;
   logic [7:0]  b3_data;
   logic        b3_href;
   logic        b3_vsync;
   logic [23:0] b3_pixel;
   logic        b3_valid;
   logic [11:0] b3_x;
   logic [10:0] b3_y;
   logic        b3_sof;
   logic        b3_eol;
   logic        b3_eof;
   logic        b3_err;
   logic [15:0] b3_fcnt;

   cam_pixel_capture #(
      .BUS_W(8), .BYTES_PER_PIX(BPP), .H_ACTIVE(HACT), .X_W(12), .Y_W(11), .VS_POL(VSP)
   ) u_dut (
      .i_pclk(clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_href(i_href), .i_vsync(i_vsync),
      .i_skip(i_skip), .o_pixel(o_pixel), .o_valid(o_valid), .o_x(o_x), .o_y(o_y),
      .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof), .o_line_err(o_line_err),
      .o_frame_cnt(o_frame_cnt)
   );

   cam_pixel_capture #(
      .BUS_W(8), .BYTES_PER_PIX(3), .H_ACTIVE(2), .X_W(12), .Y_W(11), .VS_POL(1'b1)
   ) u_dut3 (
      .i_pclk(clk), .i_rst_n(b3_rst_n), .i_data(b3_data), .i_href(b3_href), .i_vsync(b3_vsync),
      .i_skip(4'd0), .o_pixel(b3_pixel), .o_valid(b3_valid), .o_x(b3_x), .o_y(b3_y),
      .o_sof(b3_sof), .o_eol(b3_eol), .o_eof(b3_eof), .o_line_err(b3_err),
      .o_frame_cnt(b3_fcnt)
   );

   typedef struct packed {
      logic        v;
      logic [15:0] pix;
      logic [11:0] x;
      logic [10:0] y;
      logic        sof;
      logic        eol;
      logic        err;
      logic        eof;
   } ev_t;

   ev_t exp_a [int];

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;
   logic rst_smp = 1'b0;
   logic [15:0] fcnt_exp = 16'd0;

   // Observation counters, cleared per test by the stimulus process
   int n_valid, n_sof, n_eol, n_err, n_eof;
   logic [15:0] first_pix, last_pix;
   logic [11:0] first_x, last_x;
   logic [10:0] first_y, last_y;

   // Reference model state (frame/line level)
   int m_mode = MWait;
   int m_skip_left = 0;
   int m_y = 0;
   int m_npix = 0;
   int m_bcnt = 0;
   logic [15:0] m_acc = 16'd0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_smp <= i_rst_n;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void add_ev(input int t, input ev_t e);
      if (exp_a.exists(t)) exp_a[t] = ev_t'(exp_a[t] | e);
      else exp_a[t] = e;
   endfunction

   task automatic clr_counts();
      n_valid = 0; n_sof = 0; n_eol = 0; n_err = 0; n_eof = 0;
      first_pix = '0; last_pix = '0; first_x = '0; last_x = '0; first_y = '0; last_y = '0;
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!rst_smp) begin
         fcnt_exp = 16'd0;
         chk("reset_outputs", {o_pixel, o_valid, o_x, o_y, o_sof, o_eol, o_eof, o_line_err,
             o_frame_cnt}, 64'd0);
      end else begin
         e = '0;
         if (exp_a.exists(cyc)) begin
            e = exp_a[cyc];
            exp_a.delete(cyc);
         end
         chk("valid", o_valid, e.v);
         if (e.v) begin
            chk("pixel", o_pixel, e.pix);
            chk("x", o_x, e.x);
            chk("y", o_y, e.y);
         end
         chk("sof", o_sof, e.sof);
         chk("eol", o_eol, e.eol);
         chk("line_err", o_line_err, e.err);
         chk("eof", o_eof, e.eof);
         if (e.eof) fcnt_exp = fcnt_exp + 16'd1;
         chk("frame_cnt", o_frame_cnt, fcnt_exp);
      end
      if (o_valid) begin
         if (n_valid == 0) begin
            first_pix = o_pixel; first_x = o_x; first_y = o_y;
         end
         last_pix = o_pixel; last_x = o_x; last_y = o_y;
         n_valid++;
      end
      n_sof += int'(o_sof);
      n_eol += int'(o_eol);
      n_err += int'(o_line_err);
      n_eof += int'(o_eof);
   end

   // Inputs sampled at the next edge; their registered effects show at cycle t+1
   task automatic drive(input logic href, input logic [7:0] d, input logic vs, input logic rst_n,
                        output int t);
      i_href  = href;
      i_data  = d;
      i_vsync = vs ? VSP : ~VSP;
      i_rst_n = rst_n;
      t = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      int t;
      repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b1, t);
   endtask

   task automatic do_reset(input int n, input logic href);
      int t;
      repeat (n) drive(href, 8'h77, 1'b0, 1'b0, t);
      m_mode = MWait; m_skip_left = 0; m_y = 0; m_npix = 0; m_bcnt = 0;
   endtask

   task automatic send_bytes(input int n, input logic [7:0] start);
      int t;
      ev_t e;
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = start + 8'(i);
         drive(1'b1, b, 1'b0, 1'b1, t);
         if (m_mode == MCap) begin
            m_acc = (m_acc << 8) | 16'(b);
            m_bcnt++;
            if (m_bcnt == BPP) begin
               e = '0;
               e.v = 1'b1; e.pix = m_acc; e.x = 12'(m_npix); e.y = 11'(m_y);
               e.sof = (m_npix == 0) && (m_y == 0);
               add_ev(t + 1, e);
               m_npix++;
               m_bcnt = 0;
            end
         end
      end
   endtask

   task automatic end_line(input int gap);
      int t;
      ev_t e;
      drive(1'b0, 8'h00, 1'b0, 1'b1, t);
      if (m_mode == MCap) begin
         e = '0;
         e.eol = 1'b1;
         e.err = (m_bcnt != 0) || (m_npix != HACT);
         add_ev(t + 1, e);
         if (m_npix > 0) m_y++;
      end
      m_npix = 0; m_bcnt = 0;
      idle(gap - 1);
   endtask

   task automatic send_line(input int n, input logic [7:0] start, input int gap);
      send_bytes(n, start);
      end_line(gap);
   endtask

   task automatic vsync_pulse(input int n, input logic keep_href);
      int t;
      ev_t e;
      drive(keep_href, 8'hEE, 1'b1, 1'b1, t);
      if (m_mode == MCap) begin
         e = '0;
         e.eof = 1'b1;
         add_ev(t + 1, e);
         m_skip_left = int'(i_skip);
      end else if (m_mode == MSkip) begin
         m_skip_left--;
      end
      repeat (n - 1) drive(1'b0, 8'h00, 1'b1, 1'b1, t);
      drive(1'b0, 8'h00, 1'b0, 1'b1, t);
      m_mode = (m_skip_left == 0) ? MCap : MSkip;
      m_y = 0; m_npix = 0; m_bcnt = 0;
   endtask

   task automatic b3_step(input logic href, input logic [7:0] d, input logic vs,
                          input logic rst_n);
      b3_href = href; b3_data = d; b3_vsync = vs; b3_rst_n = rst_n;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int v0;
      i_rst_n = 1'b0; i_data = 8'h00; i_href = 1'b0; i_vsync = ~VSP; i_skip = 4'd0;
      b3_rst_n = 1'b0; b3_data = 8'h00; b3_href = 1'b0; b3_vsync = 1'b0;
      clr_counts();

      // T1: reset mid-line, then no capture until a full VSYNC pulse
      do_reset(3, 1'b0);
      idle(2);
      vsync_pulse(2, 1'b0);
      send_bytes(3, 8'h50);
      do_reset(3, 1'b1);
      clr_counts();
      send_line(8, 8'h60, 3);
      idle(2);
      chk("t1_no_valid_before_vsync", n_valid, 0);
      chk("t1_frame_cnt", o_frame_cnt, 0);
      vsync_pulse(2, 1'b0);

      // T2: 4x2 frame, bytes 0x01..0x10
      clr_counts();
      send_line(8, 8'h01, 3);
      send_line(8, 8'h09, 3);
      vsync_pulse(2, 1'b0);
      chk("t2_valid_count", n_valid, 8);
      chk("t2_first_pixel", first_pix, 16'h0102);
      chk("t2_last_pixel", last_pix, 16'h0F10);
      chk("t2_last_x", last_x, 12'd3);
      chk("t2_last_y", last_y, 11'd1);
      chk("t2_sof_count", n_sof, 1);
      chk("t2_eol_count", n_eol, 2);
      chk("t2_err_count", n_err, 0);
      chk("t2_eof_count", n_eof, 1);
      chk("t2_frame_cnt", o_frame_cnt, 16'd1);

      // T3: 7-byte line is short and leaves a partial pixel
      clr_counts();
      send_line(7, 8'h20, 3);
      send_line(8, 8'h30, 3);
      chk("t3_valid_count", n_valid, 7);
      chk("t3_eol_count", n_eol, 2);
      chk("t3_err_count", n_err, 1);
      chk("t3_last_y", last_y, 11'd1);
      vsync_pulse(2, 1'b0);

      // T5: VSYNC mid-line drops the line, next frame restarts at y=0
      clr_counts();
      send_line(8, 8'h40, 3);
      send_bytes(3, 8'h48);
      vsync_pulse(2, 1'b1);
      idle(1);
      chk("t5_eol_count", n_eol, 1);
      chk("t5_eof_count", n_eof, 1);
      chk("t5_valid_count", n_valid, 5);
      clr_counts();
      send_line(8, 8'h50, 3);
      chk("t5_next_first_y", first_y, 11'd0);
      chk("t5_next_first_x", first_x, 12'd0);
      chk("t5_next_first_pixel", first_pix, 16'h5051);
      chk("t5_next_sof", n_sof, 1);
      vsync_pulse(2, 1'b0);
      chk("t5_frame_cnt", o_frame_cnt, 16'd4);

      // T4: skip 2 frames after each captured one
      do_reset(2, 1'b0);
      idle(1);
      i_skip = 4'd2;
      vsync_pulse(2, 1'b0);
      clr_counts();
      for (int f = 0; f < 6; f++) begin
         v0 = n_valid;
         send_line(8, 8'h80 + 8'(16 * f), 3);
         vsync_pulse(2, 1'b0);
         chk("t4_frame_valids", n_valid - v0, (f == 0 || f == 3) ? 4 : 0);
      end
      chk("t4_eof_count", n_eof, 2);
      chk("t4_frame_cnt", o_frame_cnt, 16'd2);
      i_skip = 4'd0;
      send_line(8, 8'hC0, 3);
      vsync_pulse(2, 1'b0);

      // T6: three-word pixels on the second instance
      b3_step(1'b0, 8'h00, 1'b0, 1'b0);
      b3_step(1'b0, 8'h00, 1'b0, 1'b0);
      b3_step(1'b0, 8'h00, 1'b1, 1'b1);
      b3_step(1'b0, 8'h00, 1'b0, 1'b1);
      b3_step(1'b1, 8'hAA, 1'b0, 1'b1);
      chk("t6_no_valid_aa", b3_valid, 1'b0);
      b3_step(1'b1, 8'hBB, 1'b0, 1'b1);
      chk("t6_no_valid_bb", b3_valid, 1'b0);
      b3_step(1'b1, 8'hCC, 1'b0, 1'b1);
      chk("t6_valid_cc", b3_valid, 1'b1);
      chk("t6_pixel_aabbcc", b3_pixel, 24'hAABBCC);
      chk("t6_x0", b3_x, 12'd0);
      chk("t6_sof", b3_sof, 1'b1);
      b3_step(1'b1, 8'hDD, 1'b0, 1'b1);
      chk("t6_no_valid_dd", b3_valid, 1'b0);
      b3_step(1'b1, 8'hEE, 1'b0, 1'b1);
      b3_step(1'b1, 8'hFF, 1'b0, 1'b1);
      chk("t6_pixel_ddeeff", b3_pixel, 24'hDDEEFF);
      chk("t6_x1", b3_x, 12'd1);
      chk("t6_no_sof", b3_sof, 1'b0);
      b3_step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t6_eol", b3_eol, 1'b1);
      chk("t6_no_err", b3_err, 1'b0);
      chk("t6_pixel_hold", b3_pixel, 24'hDDEEFF);
      b3_step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("t6_eof", b3_eof, 1'b1);
      chk("t6_frame_cnt", b3_fcnt, 16'd1);

      idle(3);
      chk("pending_events", exp_a.num(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
